// File: rtl/scr1_timer_mc_if.sv
// rtl/scr1_timer_mc_if.sv - dmem bus types and interface for the multi-channel machine timer
`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif
`ifndef SCR1_DMEM_DWIDTH
`define SCR1_DMEM_DWIDTH 32
`endif

package scr1_timer_mc_pkg;
   typedef enum logic {
      SCR1_MEM_CMD_RD = 1'b0,
      SCR1_MEM_CMD_WR = 1'b1
   } type_scr1_mem_cmd_e;

   typedef enum logic [1:0] {
      SCR1_MEM_WIDTH_BYTE  = 2'b00,
      SCR1_MEM_WIDTH_HWORD = 2'b01,
      SCR1_MEM_WIDTH_WORD  = 2'b10,
      SCR1_MEM_WIDTH_ERROR = 2'b11
   } type_scr1_mem_width_e;

   typedef enum logic [1:0] {
      SCR1_MEM_RESP_NOTRDY = 2'b00,
      SCR1_MEM_RESP_RDY_OK = 2'b01,
      SCR1_MEM_RESP_RDY_ER = 2'b10
   } type_scr1_mem_resp_e;
endpackage

interface scr1_timer_mc_if;
   import scr1_timer_mc_pkg::*;

   logic                          req;
   type_scr1_mem_cmd_e            cmd;
   type_scr1_mem_width_e          width;
   logic [`SCR1_DMEM_AWIDTH-1:0]  addr;
   logic [`SCR1_DMEM_DWIDTH-1:0]  wdata;
   logic                          req_ack;
   logic [`SCR1_DMEM_DWIDTH-1:0]  rdata;
   type_scr1_mem_resp_e           resp;

   modport master (output req, cmd, width, addr, wdata, input req_ack, rdata, resp);
   modport slave  (input req, cmd, width, addr, wdata, output req_ack, rdata, resp);
endinterface

// File: rtl/scr1_timer_mc.sv
// rtl/scr1_timer_mc.sv - 64-bit mtime with prescaler and N_CH one-shot/periodic compare channels
`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif
`ifndef SCR1_DMEM_DWIDTH
`define SCR1_DMEM_DWIDTH 32
`endif

module scr1_timer_mc
   import scr1_timer_mc_pkg::*;
#(
   parameter int N_CH      = 4,
   parameter int DIV_WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ext_tick_i,
   scr1_timer_mc_if.slave   dmem,
   output logic [63:0]      timer_val_o,
   output logic [N_CH-1:0]  irq_vec_o,
   output logic             timer_irq_o
);

   localparam logic [7:0] OFF_CONTROL = 8'h00;
   localparam logic [7:0] OFF_DIVIDER = 8'h04;
   localparam logic [7:0] OFF_MTIMELO = 8'h08;
   localparam logic [7:0] OFF_MTIMEHI = 8'h0C;
   localparam logic [7:0] OFF_PEND    = 8'h10;
   localparam logic [7:0] OFF_IRQEN   = 8'h14;

   logic                  en_q, en_d, clksrc_q, clksrc_d;
   logic [DIV_WIDTH-1:0]  div_q, div_d, cnt_q, cnt_d;
   logic [63:0]           mtime_q, mtime_d, mtime_inc;
   logic [N_CH-1:0]       pend_q, pend_d, irqen_q, irqen_d;
   logic [63:0]           cmp_q [N_CH];
   logic [63:0]           cmp_d [N_CH];
   logic [31:0]           period_q [N_CH];
   logic [31:0]           period_d [N_CH];
   logic [N_CH-1:0]       periodic_q, periodic_d, chen_q, chen_d, armed_q, armed_d;
   logic [2:0]            sync_q, sync_d;
   type_scr1_mem_resp_e   resp_q, resp_d;
   logic [31:0]           rdata_q, rdata_d;

   logic [7:0]            off;
   logic [3:0]            ch_idx;
   logic                  ch_area, mapped, acc_ok, wr_en, rd_en;
   logic [31:0]           wdata, rd_data;
   logic [N_CH-1:0]       ch_sel, cmplo_wr, cmphi_wr, period_wr, chctrl_wr, match, hit;
   logic                  ext_pulse, tick_en, tick_zero;
   logic                  unused_addr;

   assign off         = dmem.addr[7:0];
   assign wdata       = dmem.wdata;
   assign unused_addr = ^dmem.addr[`SCR1_DMEM_AWIDTH-1:8];

   // Channel k lives at 0x20+0x10*k; anything at or beyond N_CH is unmapped.
   assign ch_idx  = off[7:4] - 4'd2;
   assign ch_area = (off[7:4] >= 4'd2) && (int'(ch_idx) < N_CH);
   assign mapped  = ch_area || (off[7:4] == 4'h0) || (off == OFF_PEND) || (off == OFF_IRQEN);
   assign acc_ok  = dmem.req && (dmem.width == SCR1_MEM_WIDTH_WORD)
                    && (dmem.addr[1:0] == 2'b00) && mapped;
   assign wr_en   = acc_ok && (dmem.cmd == SCR1_MEM_CMD_WR);
   assign rd_en   = acc_ok && (dmem.cmd == SCR1_MEM_CMD_RD);

   always_comb begin
      ch_sel    = '0;
      cmplo_wr  = '0;
      cmphi_wr  = '0;
      period_wr = '0;
      chctrl_wr = '0;
      for (int k = 0; k < N_CH; k++) begin
         ch_sel[k]    = ch_area && (ch_idx == 4'(k));
         cmplo_wr[k]  = wr_en && ch_sel[k] && (off[3:2] == 2'd0);
         cmphi_wr[k]  = wr_en && ch_sel[k] && (off[3:2] == 2'd1);
         period_wr[k] = wr_en && ch_sel[k] && (off[3:2] == 2'd2);
         chctrl_wr[k] = wr_en && ch_sel[k] && (off[3:2] == 2'd3);
      end
   end

   always_comb begin
      rd_data = '0;
      case (off)
         OFF_CONTROL: rd_data[1:0] = {clksrc_q, en_q};
         OFF_DIVIDER: rd_data[DIV_WIDTH-1:0] = div_q;
         OFF_MTIMELO: rd_data = mtime_q[31:0];
         OFF_MTIMEHI: rd_data = mtime_q[63:32];
         OFF_PEND:    rd_data[N_CH-1:0] = pend_q;
         OFF_IRQEN:   rd_data[N_CH-1:0] = irqen_q;
         default:     ;
      endcase
      for (int k = 0; k < N_CH; k++) begin
         if (ch_sel[k]) begin
            case (off[3:2])
               2'd0:    rd_data = cmp_q[k][31:0];
               2'd1:    rd_data = cmp_q[k][63:32];
               2'd2:    rd_data = period_q[k];
               default: rd_data[1:0] = {chen_q[k], periodic_q[k]};
            endcase
         end
      end
   end

   always_comb begin
      // Oldest two synchronizer stages differ exactly once per ext_tick edge.
      ext_pulse = sync_q[2] ^ sync_q[1];
      tick_en   = en_q && (clksrc_q ? ext_pulse : 1'b1);
      tick_zero = tick_en && (cnt_q == '0);
      sync_d    = clksrc_q ? {sync_q[1:0], ext_tick_i} : 3'b000;

      en_d     = en_q;
      clksrc_d = clksrc_q;
      div_d    = div_q;
      irqen_d  = irqen_q;
      if (wr_en && (off == OFF_CONTROL)) begin
         en_d     = wdata[0];
         clksrc_d = wdata[1];
      end
      if (wr_en && (off == OFF_DIVIDER)) div_d = wdata[DIV_WIDTH-1:0];
      if (wr_en && (off == OFF_IRQEN))   irqen_d = wdata[N_CH-1:0];

      cnt_d = cnt_q;
      if (wr_en && (off == OFF_DIVIDER)) cnt_d = wdata[DIV_WIDTH-1:0];
      else if (tick_zero)                cnt_d = div_q;
      else if (tick_en)                  cnt_d = cnt_q - DIV_WIDTH'(1);

      mtime_inc = mtime_q + 64'(tick_zero);
      mtime_d   = mtime_inc;
      if (wr_en && (off == OFF_MTIMELO)) mtime_d[31:0]  = wdata;
      if (wr_en && (off == OFF_MTIMEHI)) mtime_d[63:32] = wdata;

      match      = '0;
      hit        = '0;
      periodic_d = periodic_q;
      chen_d     = chen_q;
      armed_d    = armed_q;
      for (int k = 0; k < N_CH; k++) begin
         cmp_d[k]    = cmp_q[k];
         period_d[k] = period_q[k];
         match[k]    = chen_q[k] && armed_q[k] && (mtime_q >= cmp_q[k]);
         // A software compare/control write in the match cycle takes precedence.
         hit[k]      = match[k] && !(cmplo_wr[k] || cmphi_wr[k] || chctrl_wr[k]);
         if (hit[k]) begin
            if (periodic_q[k] && (period_q[k] != '0)) cmp_d[k] = cmp_q[k] + {32'd0, period_q[k]};
            else                                      armed_d[k] = 1'b0;
         end
         if (cmplo_wr[k]) begin
            cmp_d[k][31:0] = wdata;
            armed_d[k]     = 1'b1;
         end
         if (cmphi_wr[k]) begin
            cmp_d[k][63:32] = wdata;
            armed_d[k]      = 1'b1;
         end
         if (period_wr[k]) period_d[k] = wdata;
         if (chctrl_wr[k]) begin
            periodic_d[k] = wdata[0];
            chen_d[k]     = wdata[1];
            armed_d[k]    = 1'b1;
         end
      end

      pend_d = pend_q;
      if (wr_en && (off == OFF_PEND)) pend_d = pend_q & ~wdata[N_CH-1:0];
      pend_d = pend_d | hit;

      resp_d  = SCR1_MEM_RESP_NOTRDY;
      rdata_d = '0;
      if (dmem.req) begin
         resp_d  = acc_ok ? SCR1_MEM_RESP_RDY_OK : SCR1_MEM_RESP_RDY_ER;
         rdata_d = rd_en ? rd_data : rdata_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en_q       <= 1'b1;
         clksrc_q   <= 1'b0;
         div_q      <= '0;
         cnt_q      <= '0;
         mtime_q    <= '0;
         pend_q     <= '0;
         irqen_q    <= '0;
         periodic_q <= '0;
         chen_q     <= '0;
         armed_q    <= '1;
         sync_q     <= '0;
         resp_q     <= SCR1_MEM_RESP_NOTRDY;
         rdata_q    <= '0;
         for (int k = 0; k < N_CH; k++) begin
            cmp_q[k]    <= '1;
            period_q[k] <= '0;
         end
      end else begin
         en_q       <= en_d;
         clksrc_q   <= clksrc_d;
         div_q      <= div_d;
         cnt_q      <= cnt_d;
         mtime_q    <= mtime_d;
         pend_q     <= pend_d;
         irqen_q    <= irqen_d;
         periodic_q <= periodic_d;
         chen_q     <= chen_d;
         armed_q    <= armed_d;
         sync_q     <= sync_d;
         resp_q     <= resp_d;
         rdata_q    <= rdata_d;
         for (int k = 0; k < N_CH; k++) begin
            cmp_q[k]    <= cmp_d[k];
            period_q[k] <= period_d[k];
         end
      end
   end

   assign dmem.req_ack = 1'b1;
   assign dmem.rdata   = rdata_q;
   assign dmem.resp    = resp_q;
   assign timer_val_o  = mtime_q;
   assign irq_vec_o    = pend_q & irqen_q;
   assign timer_irq_o  = |irq_vec_o;

endmodule

// File: tb/tb_scr1_timer_mc.sv
// tb/tb_scr1_timer_mc.sv - directed self-checking bench for scr1_timer_mc
module tb_scr1_timer_mc;
   import scr1_timer_mc_pkg::*;

   logic        clk, rst, ext_tick;
   logic [63:0] timer_val;
   logic [3:0]  irq_vec;
   logic        timer_irq;
   int          checks, errors;

   scr1_timer_mc_if dmem_if();

   scr1_timer_mc #(.N_CH(4), .DIV_WIDTH(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .ext_tick_i  (ext_tick),
      .dmem        (dmem_if),
      .timer_val_o (timer_val),
      .irq_vec_o   (irq_vec),
      .timer_irq_o (timer_irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic bus(input type_scr1_mem_cmd_e cmd, input type_scr1_mem_width_e w, input logic [7:0] a,
                      input logic [31:0] d, output logic [31:0] rdv, output type_scr1_mem_resp_e rs);
      dmem_if.req   = 1'b1;
      dmem_if.cmd   = cmd;
      dmem_if.width = w;
      dmem_if.addr  = {24'd0, a};
      dmem_if.wdata = d;
      @(posedge clk);
      #1;
      rdv = dmem_if.rdata;
      rs  = dmem_if.resp;
      dmem_if.req = 1'b0;
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      logic [31:0] rdv;
      type_scr1_mem_resp_e rs;
      bus(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, a, d, rdv, rs);
   endtask

   task automatic rd(input logic [7:0] a, output logic [31:0] d, output type_scr1_mem_resp_e rs);
      bus(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, a, 32'd0, d, rs);
   endtask

   task automatic test_reset();
      logic [31:0] d;
      type_scr1_mem_resp_e r;
      #12;
      checks++; if (timer_val !== 64'd0 || timer_irq !== 1'b0) begin errors++; $display("FAIL rst_outputs: mtime %0d irq %b want 0 0", timer_val, timer_irq); end
      checks++; if (dmem_if.resp !== SCR1_MEM_RESP_NOTRDY || dmem_if.rdata !== 32'd0) begin errors++; $display("FAIL rst_bus: resp %0d rdata %h want 0 0", dmem_if.resp, dmem_if.rdata); end
      @(posedge clk); #1; rst = 1'b0;
      rd(8'h00, d, r);
      checks++; if (d !== 32'h1 || r !== SCR1_MEM_RESP_RDY_OK) begin errors++; $display("FAIL rst_control: got %h resp %0d want 00000001 resp 1", d, r); end
      rd(8'h04, d, r);
      checks++; if (d !== 32'h0 || r !== SCR1_MEM_RESP_RDY_OK) begin errors++; $display("FAIL rst_divider: got %h resp %0d want 0 resp 1", d, r); end
      rd(8'h0C, d, r);
      checks++; if (d !== 32'h0 || r !== SCR1_MEM_RESP_RDY_OK) begin errors++; $display("FAIL rst_mtimehi: got %h resp %0d want 0 resp 1", d, r); end
      rd(8'h20, d, r);
      checks++; if (d !== 32'hFFFF_FFFF || r !== SCR1_MEM_RESP_RDY_OK) begin errors++; $display("FAIL rst_cmp0lo: got %h want ffffffff", d); end
      rd(8'h24, d, r);
      checks++; if (d !== 32'hFFFF_FFFF || r !== SCR1_MEM_RESP_RDY_OK) begin errors++; $display("FAIL rst_cmp0hi: got %h want ffffffff", d); end
      rd(8'h10, d, r);
      checks++; if (d !== 32'h0 || timer_irq !== 1'b0) begin errors++; $display("FAIL rst_pend: got %h irq %b want 0 0", d, timer_irq); end
   endtask

   task automatic test_prescaler();
      logic [31:0] d;
      type_scr1_mem_resp_e r;
      wr(8'h00, 32'h0); wr(8'h08, 32'h0); wr(8'h0C, 32'h0); wr(8'h04, 32'd3);
      wr(8'h20, 32'd10); wr(8'h24, 32'h0); wr(8'h14, 32'h1); wr(8'h2C, 32'h2);
      wr(8'h00, 32'h1);
      repeat (3) @(posedge clk); #1;
      checks++; if (timer_val !== 64'd0) begin errors++; $display("FAIL presc_hold: mtime %0d want 0", timer_val); end
      @(posedge clk); #1;
      checks++; if (timer_val !== 64'd1) begin errors++; $display("FAIL presc_first: mtime %0d want 1", timer_val); end
      repeat (4) @(posedge clk); #1;
      checks++; if (timer_val !== 64'd2) begin errors++; $display("FAIL presc_second: mtime %0d want 2", timer_val); end
      repeat (32) @(posedge clk); #1;
      checks++; if (timer_val !== 64'd10 || timer_irq !== 1'b0) begin errors++; $display("FAIL presc_pre_match: mtime %0d irq %b want 10 0", timer_val, timer_irq); end
      @(posedge clk); #1;
      checks++; if (timer_irq !== 1'b1 || irq_vec !== 4'b0001) begin errors++; $display("FAIL presc_match: irq %b vec %b want 1 0001", timer_irq, irq_vec); end
      rd(8'h10, d, r);
      checks++; if (d !== 32'h1) begin errors++; $display("FAIL presc_pend_read: got %h want 00000001", d); end
      wr(8'h10, 32'h1);
      repeat (5) @(posedge clk); #1;
      checks++; if (timer_irq !== 1'b0 || irq_vec !== 4'b0000) begin errors++; $display("FAIL presc_oneshot_clear: irq %b vec %b want 0 0000", timer_irq, irq_vec); end
      rd(8'h10, d, r);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL presc_pend_after_w1c: got %h want 0", d); end
   endtask

   task automatic test_periodic();
      logic [31:0] d;
      type_scr1_mem_resp_e r;
      bit found;
      wr(8'h00, 32'h0); wr(8'h08, 32'h0); wr(8'h0C, 32'h0); wr(8'h04, 32'h0);
      wr(8'h2C, 32'h0); wr(8'h30, 32'd100); wr(8'h34, 32'h0); wr(8'h38, 32'd50);
      wr(8'h3C, 32'h3); wr(8'h14, 32'h3); wr(8'h00, 32'h1);
      for (int e = 0; e < 3; e++) begin
         found = 1'b0;
         for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk); #1;
            found = irq_vec[1];
         end
         checks++; if (!found || timer_val !== 64'(101 + 50 * e)) begin errors++; $display("FAIL periodic_event%0d: seen %b mtime %0d want 1 %0d", e, found, timer_val, 101 + 50 * e); end
         if (e < 2) wr(8'h10, 32'h2);
      end
      rd(8'h30, d, r);
      checks++; if (d !== 32'd250) begin errors++; $display("FAIL periodic_cmp_adv: got %0d want 250", d); end
      rd(8'h34, d, r);
      checks++; if (d !== 32'd0) begin errors++; $display("FAIL periodic_cmp_hi: got %h want 0", d); end
   endtask

   task automatic test_simultaneous();
      logic [31:0] d;
      type_scr1_mem_resp_e r;
      bit found;
      wr(8'h10, 32'h2);
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin @(posedge clk); #1; found = (timer_val === 64'd250); end
      checks++; if (!found) begin errors++; $display("FAIL sim_reach250: mtime %0d want 250", timer_val); end
      wr(8'h10, 32'h2);
      checks++; if (irq_vec[1] !== 1'b1 || timer_val !== 64'd251) begin errors++; $display("FAIL sim_set_beats_w1c: pend1 %b mtime %0d want 1 251", irq_vec[1], timer_val); end
      rd(8'h30, d, r);
      checks++; if (d !== 32'd300) begin errors++; $display("FAIL sim_cmp_after_set: got %0d want 300", d); end
      wr(8'h10, 32'h2);
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin @(posedge clk); #1; found = (timer_val === 64'd300); end
      checks++; if (!found) begin errors++; $display("FAIL sim_reach300: mtime %0d want 300", timer_val); end
      wr(8'h30, 32'd400);
      checks++; if (irq_vec[1] !== 1'b0) begin errors++; $display("FAIL sim_cmpwr_beats_match: pend1 %b want 0", irq_vec[1]); end
      rd(8'h30, d, r);
      checks++; if (d !== 32'd400 || irq_vec[1] !== 1'b0) begin errors++; $display("FAIL sim_cmpwr_value: got %0d pend1 %b want 400 0", d, irq_vec[1]); end
   endtask

   task automatic test_bus_errors();
      logic [31:0] d;
      type_scr1_mem_resp_e r;
      rd(8'h00, d, r);
      checks++; if (d !== 32'h1 || r !== SCR1_MEM_RESP_RDY_OK) begin errors++; $display("FAIL err_pre_read: got %h resp %0d want 1 resp 1", d, r); end
      bus(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 8'h0A, 32'h5, d, r);
      checks++; if (r !== SCR1_MEM_RESP_RDY_ER || d !== 32'h1) begin errors++; $display("FAIL err_misaligned: resp %0d rdata %h want 2 00000001", r, d); end
      rd(8'h60, d, r);
      checks++; if (r !== SCR1_MEM_RESP_RDY_ER || d !== 32'h1) begin errors++; $display("FAIL err_chan_rd: resp %0d rdata %h want 2 00000001", r, d); end
      wr(8'h60, 32'h1234);
      rd(8'h18, d, r);
      checks++; if (r !== SCR1_MEM_RESP_RDY_ER) begin errors++; $display("FAIL err_hole: resp %0d want 2", r); end
      bus(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_HWORD, 8'h04, 32'h7, d, r);
      checks++; if (r !== SCR1_MEM_RESP_RDY_ER) begin errors++; $display("FAIL err_hword: resp %0d want 2", r); end
      rd(8'h04, d, r);
      checks++; if (d !== 32'h0 || r !== SCR1_MEM_RESP_RDY_OK) begin errors++; $display("FAIL err_divider_kept: got %h resp %0d want 0 resp 1", d, r); end
      rd(8'h20, d, r);
      checks++; if (d !== 32'd10) begin errors++; $display("FAIL err_cmp0_kept: got %h want 0000000a", d); end
      @(posedge clk); #1;
      checks++; if (dmem_if.resp !== SCR1_MEM_RESP_NOTRDY || dmem_if.rdata !== 32'h0) begin errors++; $display("FAIL err_idle: resp %0d rdata %h want 0 0", dmem_if.resp, dmem_if.rdata); end
   endtask

   task automatic test_ext_tick();
      logic [31:0] d;
      type_scr1_mem_resp_e r;
      wr(8'h00, 32'h0); wr(8'h08, 32'h0); wr(8'h0C, 32'h0); wr(8'h00, 32'h3);
      for (int i = 1; i <= 5; i++) begin
         ext_tick = ~ext_tick;
         repeat (2) @(posedge clk); #1;
         checks++; if (timer_val !== 64'(i - 1)) begin errors++; $display("FAIL ext_early%0d: mtime %0d want %0d", i, timer_val, i - 1); end
         @(posedge clk); #1;
         checks++; if (timer_val !== 64'(i)) begin errors++; $display("FAIL ext_tick%0d: mtime %0d want %0d", i, timer_val, i); end
      end
      wr(8'h08, 32'd20); wr(8'h04, 32'd5); wr(8'h2C, 32'h2);
      rd(8'h00, d, r);
      checks++; if (d !== 32'h3 || timer_irq !== 1'b1 || timer_val !== 64'd20) begin errors++; $display("FAIL ext_pre_reset: ctrl %h irq %b mtime %0d want 3 1 20", d, timer_irq, timer_val); end
      #2; rst = 1'b1; #1;
      checks++; if (timer_val !== 64'd0 || irq_vec !== 4'b0 || timer_irq !== 1'b0) begin errors++; $display("FAIL async_reset_timer: mtime %0d vec %b irq %b want 0", timer_val, irq_vec, timer_irq); end
      checks++; if (dmem_if.resp !== SCR1_MEM_RESP_NOTRDY || dmem_if.rdata !== 32'h0) begin errors++; $display("FAIL async_reset_bus: resp %0d rdata %h want 0 0", dmem_if.resp, dmem_if.rdata); end
      @(posedge clk); #1; rst = 1'b0;
      rd(8'h00, d, r);
      checks++; if (d !== 32'h1) begin errors++; $display("FAIL post_reset_control: got %h want 1", d); end
      rd(8'h04, d, r);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL post_reset_divider: got %h want 0", d); end
      rd(8'h20, d, r);
      checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL post_reset_cmp0: got %h want ffffffff", d); end
      rd(8'h3C, d, r);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL post_reset_chctrl1: got %h want 0", d); end
      rd(8'h10, d, r);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL post_reset_pend: got %h want 0", d); end
      rd(8'h14, d, r);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL post_reset_irqen: got %h want 0", d); end
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      rst           = 1'b1;
      ext_tick      = 1'b0;
      dmem_if.req   = 1'b0;
      dmem_if.cmd   = SCR1_MEM_CMD_RD;
      dmem_if.width = SCR1_MEM_WIDTH_WORD;
      dmem_if.addr  = '0;
      dmem_if.wdata = '0;
      test_reset();
      test_prescaler();
      test_periodic();
      test_simultaneous();
      test_bus_errors();
      test_ext_tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
